// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: cooker-hood mode controller with fan levels, turbo, clean and cool-down timers.
// Ports: clk, buttom_rst (sync, active-high); sign_* single-cycle press pulses;
//   state (FSM code), fan_level, countdown (seconds left in timed states), light_on, reminder.
// Optional macro HOOD_REMINDER_EN adds the fan run-time accumulator that drives reminder.
module hood_mode_ctrl #(
  parameter int CLK_HZ        = 100000000,
  parameter int LEVELS        = 3,
  parameter int TURBO_SEC     = 60,
  parameter int CLEAN_SEC     = 180,
  parameter int COOL_SEC      = 30,
  parameter int RUN_LIMIT_SEC = 36000,
  localparam int FW           = $clog2(LEVELS + 2)
) (
  input  logic          clk,
  input  logic          buttom_rst,
  input  logic          sign_power,
  input  logic          sign_up,
  input  logic          sign_down,
  input  logic          sign_turbo,
  input  logic          sign_clean,
  input  logic          sign_light,
  output logic [2:0]    state,
  output logic [FW-1:0] fan_level,
  output logic [15:0]   countdown,
  output logic          light_on,
  output logic          reminder
);
  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_STBY = 3'd1, S_RUN = 3'd2, S_TURBO = 3'd3, S_CLEAN = 3'd4, S_COOL = 3'd5
  } state_t;

  state_t         st_q, st_d;
  logic [FW-1:0]  fan_q, fan_d, rem_q, rem_d, lvl;
  logic [15:0]    cd_q, cd_d, cnt;
  logic [31:0]    presc_q, presc_d;
  logic           light_q, light_d, used_q, used_d;
  logic           tick, done, p_pw, p_cl, p_tb, p_up, p_dn, p_lt;

  // Only the highest-priority press of a cycle is seen; light needs a cycle with no other press.
  assign p_pw = sign_power;
  assign p_cl = sign_clean & ~sign_power;
  assign p_tb = sign_turbo & ~sign_power & ~sign_clean;
  assign p_up = sign_up & ~sign_power & ~sign_clean & ~sign_turbo;
  assign p_dn = sign_down & ~sign_power & ~sign_clean & ~sign_turbo & ~sign_up;
  assign p_lt = sign_light & ~(sign_power | sign_clean | sign_turbo | sign_up | sign_down);

  assign tick = presc_q == 32'(CLK_HZ - 1);
  assign done = tick && cd_q == 16'd1;

  always_comb begin
    st_d = st_q;
    lvl = fan_q;
    cnt = cd_q;
    used_d = used_q;
    rem_d = rem_q;
    case (st_q)
      S_OFF: if (p_pw) begin st_d = S_STBY; used_d = 1'b0; end
      S_STBY:
        if (p_pw) st_d = S_OFF;
        else if (p_cl) begin st_d = S_CLEAN; cnt = 16'(CLEAN_SEC); end
        else if (p_up) begin st_d = S_RUN; lvl = FW'(1); end
      S_RUN:
        if (p_pw) begin st_d = S_COOL; cnt = 16'(COOL_SEC); end
        else if (p_tb && !used_q) begin st_d = S_TURBO; cnt = 16'(TURBO_SEC); rem_d = fan_q; used_d = 1'b1; end
        else if (p_up) lvl = fan_q == FW'(LEVELS) ? fan_q : fan_q + FW'(1);
        else if (p_dn) begin
          if (fan_q == FW'(1)) st_d = S_STBY;
          else lvl = fan_q - FW'(1);
        end
      S_TURBO:
        if (p_pw) begin st_d = S_COOL; cnt = 16'(COOL_SEC); end
        else if (p_tb || done) begin st_d = S_RUN; lvl = rem_q; end
        else if (tick) cnt = cd_q - 16'd1;
      S_CLEAN:
        if (p_pw || done) st_d = S_STBY;
        else if (tick) cnt = cd_q - 16'd1;
      S_COOL:
        if (p_pw || done) st_d = S_OFF;
        else if (p_up) begin st_d = S_RUN; lvl = FW'(1); end
        else if (tick) cnt = cd_q - 16'd1;
      default: st_d = S_OFF;
    endcase
    fan_d = st_d == S_TURBO ? FW'(LEVELS + 1) : st_d == S_CLEAN ? FW'(LEVELS) :
            st_d == S_COOL ? FW'(1) : st_d == S_RUN ? lvl : '0;
    cd_d = (st_d == S_TURBO || st_d == S_CLEAN || st_d == S_COOL) ? cnt : 16'd0;
    light_d = st_d == S_OFF ? 1'b0 : (p_lt && st_q != S_OFF) ? ~light_q : light_q;
    // Restart the prescaler when a timed state is entered so its first second is full.
    presc_d = (st_d != st_q && (st_d == S_TURBO || st_d == S_CLEAN || st_d == S_COOL)) || tick ?
              32'd0 : presc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (buttom_rst) begin
      st_q <= S_OFF;
      fan_q <= '0;
      cd_q <= 16'd0;
      light_q <= 1'b0;
      presc_q <= 32'd0;
      used_q <= 1'b0;
      rem_q <= FW'(1);
    end else begin
      st_q <= st_d;
      fan_q <= fan_d;
      cd_q <= cd_d;
      light_q <= light_d;
      presc_q <= presc_d;
      used_q <= used_d;
      rem_q <= rem_d;
    end
  end

  assign state = st_q;
  assign fan_level = fan_q;
  assign countdown = cd_q;
  assign light_on = light_q;

`ifdef HOOD_REMINDER_EN
  logic [31:0] acc_q;
  logic        clean_done;
  assign clean_done = st_q == S_CLEAN && !p_pw && done;
  // Saturating count of seconds with the fan spinning; a finished clean cycle resets it.
  always_ff @(posedge clk) begin
    if (buttom_rst || clean_done) acc_q <= 32'd0;
    else if (tick && fan_q != '0 && acc_q != '1) acc_q <= acc_q + 32'd1;
  end
  assign reminder = acc_q >= 32'(RUN_LIMIT_SEC);
`else
  assign reminder = 1'b0;
`endif
endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: directed vector bench for hood_mode_ctrl with small timing parameters.
module tb_hood_mode_ctrl;
  localparam logic [5:0] PW = 6'b100000, CL = 6'b010000, TB = 6'b001000,
                         UP = 6'b000100, DN = 6'b000010, LT = 6'b000001, NO = 6'b000000;
`ifdef HOOD_REMINDER_EN
  localparam int REN = 1;
`else
  localparam int REN = 0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic sp = 1'b0, sc = 1'b0, st = 1'b0, su = 1'b0, sd = 1'b0, sl = 1'b0;
  logic [2:0] state;
  logic [2:0] fan_level;
  logic [15:0] countdown;
  logic light_on, reminder;
  int total = 0, bad = 0;

  typedef struct {
    logic [5:0] p;
    int idle;
    int st;
    int fan;
    int cd;
    int lt;
  } vec_t;
  vec_t v[$];

  hood_mode_ctrl #(
    .CLK_HZ(4), .LEVELS(3), .TURBO_SEC(3), .CLEAN_SEC(2), .COOL_SEC(2), .RUN_LIMIT_SEC(5)
  ) dut (
    .clk(clk), .buttom_rst(rst),
    .sign_power(sp), .sign_up(su), .sign_down(sd), .sign_turbo(st), .sign_clean(sc), .sign_light(sl),
    .state(state), .fan_level(fan_level), .countdown(countdown), .light_on(light_on), .reminder(reminder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int f, input int c, input int l);
    chk({tag, ".state"}, int'(state), s);
    chk({tag, ".fan"}, int'(fan_level), f);
    chk({tag, ".cd"}, int'(countdown), c);
    chk({tag, ".light"}, int'(light_on), l);
  endtask

  // Called at a negedge: hold the press for one edge, then idle for the given edges.
  task automatic apply(input logic [5:0] p, input int idle);
    {sp, sc, st, su, sd, sl} = p;
    @(negedge clk);
    {sp, sc, st, su, sd, sl} = NO;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    v.push_back('{PW, 0, 1, 0, 0, 0});
    v.push_back('{UP, 0, 2, 1, 0, 0});
    v.push_back('{UP, 0, 2, 2, 0, 0});
    v.push_back('{UP, 0, 2, 3, 0, 0});
    v.push_back('{UP, 0, 2, 3, 0, 0});
    v.push_back('{DN, 0, 2, 2, 0, 0});
    v.push_back('{TB, 0, 3, 4, 3, 0});
    v.push_back('{NO, 3, 3, 4, 2, 0});
    v.push_back('{NO, 3, 3, 4, 1, 0});
    v.push_back('{NO, 3, 2, 2, 0, 0});
    v.push_back('{TB, 0, 2, 2, 0, 0});
    v.push_back('{UP | TB, 0, 2, 2, 0, 0});
    v.push_back('{LT, 0, 2, 2, 0, 1});
    v.push_back('{PW, 0, 5, 1, 2, 1});
    v.push_back('{NO, 3, 5, 1, 1, 1});
    v.push_back('{NO, 3, 0, 0, 0, 0});
    v.push_back('{UP | LT, 0, 0, 0, 0, 0});
    v.push_back('{PW, 0, 1, 0, 0, 0});
    v.push_back('{UP, 0, 2, 1, 0, 0});
    v.push_back('{TB, 0, 3, 4, 3, 0});
    v.push_back('{TB, 0, 2, 1, 0, 0});
    v.push_back('{DN, 0, 1, 0, 0, 0});
    v.push_back('{UP, 0, 2, 1, 0, 0});
    v.push_back('{PW, 0, 5, 1, 2, 0});
    v.push_back('{UP, 0, 2, 1, 0, 0});
    v.push_back('{PW, 0, 5, 1, 2, 0});
    v.push_back('{PW, 0, 0, 0, 0, 0});
    v.push_back('{PW, 0, 1, 0, 0, 0});
    v.push_back('{PW | UP, 0, 0, 0, 0, 0});
    v.push_back('{PW, 0, 1, 0, 0, 0});
    v.push_back('{LT, 0, 1, 0, 0, 1});
    v.push_back('{CL | LT, 0, 4, 3, 2, 1});
    v.push_back('{NO, 3, 4, 3, 1, 1});
    v.push_back('{NO, 3, 1, 0, 0, 1});
    v.push_back('{CL, 0, 4, 3, 2, 1});
    v.push_back('{PW, 0, 1, 0, 0, 1});
    v.push_back('{CL, 0, 4, 3, 2, 1});
    v.push_back('{NO, 3, 4, 3, 1, 1});

    rst = 1'b1;
    sp = 1'b1;
    repeat (3) @(negedge clk);
    sp = 1'b0;
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0);
    chk("reset.rem", int'(reminder), 0);

    foreach (v[i]) begin
      apply(v[i].p, v[i].idle);
      chk_all($sformatf("vec%0d", i), v[i].st, v[i].fan, v[i].cd, v[i].lt);
    end

    // Reset mid-CLEAN with countdown 1 overrides a simultaneous power press.
    rst = 1'b1;
    sp = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sp = 1'b0;
    chk_all("rst_clean", 0, 0, 0, 0);
    chk("rst_clean.rem", int'(reminder), 0);

    // Run-time reminder: 24 cycles of RUN gives at least 5 ticks, a completed clean clears it.
    apply(PW, 0);
    apply(UP, 0);
    chk("rem.run0", int'(reminder), 0);
    apply(NO, 23);
    chk("rem.run", int'(reminder), REN);
    apply(DN, 0);
    chk("rem.stby", int'(reminder), REN);
    apply(CL, 0);
    chk_all("rem.clean", 4, 3, 2, 0);
    apply(NO, 6);
    chk("rem.clean_state", int'(state), 4);
    chk("rem.clean_mid", int'(reminder), REN);
    apply(NO, 0);
    chk("rem.done_state", int'(state), 1);
    chk("rem.done", int'(reminder), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clock cycles per 1 s tick.
REQ-002 SHALL have parameter LEVELS, default 3, number of normal fan levels (>=2).
REQ-003 SHALL have parameters TURBO_SEC 60, CLEAN_SEC 180, COOL_SEC 30, all timed-state durations in seconds (>=1).
REQ-004 SHALL have parameter RUN_LIMIT_SEC, default 36000, accumulated fan-run seconds before reminder.
REQ-005 SHALL have port clk  in  1  system clock; single clock domain.
REQ-006 SHALL have port buttom_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports sign_power, sign_up, sign_down, sign_turbo, sign_clean, sign_light  in  1 each  single-cycle press pulses.
REQ-008 SHALL have port state  out  3  FSM code: OFF=0, STANDBY=1, RUN=2, TURBO=3, CLEAN=4, COOL=5.
REQ-009 SHALL have port fan_level  out  $clog2(LEVELS+2)  0 off, 1..LEVELS normal, LEVELS+1 turbo.
REQ-010 SHALL have port countdown  out  16  remaining seconds in TURBO/CLEAN/COOL, else 0.
REQ-011 SHALL have ports light_on, reminder  out  1 each.

Function
REQ-012 SHALL derive a 1 s tick from a prescaler counting 0..CLK_HZ-1; prescaler restarts at 0 on entry to TURBO, CLEAN or COOL so the first second is full.
REQ-013 SHALL resolve same-cycle presses by priority power > clean > turbo > up > down > light; lower-priority presses in that cycle are dropped, except light, which is acted on only if no other press occurs.
REQ-014 OFF: power -> STANDBY; all other presses ignored; fan_level 0, light_on 0.
REQ-015 STANDBY: power -> OFF; up -> RUN level 1; clean -> CLEAN, countdown=CLEAN_SEC; down/turbo ignored.
REQ-016 RUN: up increments level, saturating at LEVELS; down decrements level, level 1 -> STANDBY; power -> COOL, countdown=COOL_SEC.
REQ-017 RUN: turbo -> TURBO, countdown=TURBO_SEC, remembering current level, only if turbo unused since last OFF->STANDBY; otherwise ignored.
REQ-018 TURBO: fan_level=LEVELS+1; countdown decrements per tick; on tick with countdown=1 -> RUN at remembered level; turbo press -> early return to RUN at remembered level; power -> COOL; up/down ignored.
REQ-019 CLEAN: fan_level=LEVELS; countdown decrements per tick; completion -> STANDBY; power -> STANDBY (abort, no reminder clear); other presses ignored.
REQ-020 COOL: fan_level=1; countdown decrements per tick; completion -> OFF; power -> OFF immediately; up -> RUN level 1; other presses ignored.
REQ-021 Transitions SHALL take effect on the clock edge after the press pulse; outputs registered, latency one cycle.
REQ-022 light_on SHALL toggle on sign_light in any state but OFF; SHALL clear on any entry to OFF.
REQ-023 countdown SHALL never underflow; reaching 0 and the state change occur on the same edge.

Reset
REQ-024 On buttom_rst high at a clk edge: state OFF, fan_level 0, countdown 0, light_on 0, prescaler 0, turbo-used flag 0, remembered level 1.
REQ-025 Reset SHALL override all presses in the same cycle, including mid-TURBO/CLEAN/COOL.
REQ-026 Reset SHALL clear the run-time accumulator and reminder (when REMINDER_EN defined).

Configuration
REQ-027 With macro HOOD_REMINDER_EN defined: a 32-bit accumulator counts ticks while fan_level!=0 (all states incl. CLEAN, COOL), saturating; reminder=1 once accumulator >= RUN_LIMIT_SEC; completed CLEAN clears accumulator and reminder on the completing edge.
REQ-028 Without HOOD_REMINDER_EN: accumulator absent, reminder tied 0, all other behaviour identical.

Verification (CLK_HZ=4, LEVELS=3, TURBO_SEC=3, CLEAN_SEC=2, COOL_SEC=2, RUN_LIMIT_SEC=5)
REQ-029 power, up, up, up, up -> STANDBY, RUN fan_level 1, 2, 3, 3 (saturated).
REQ-030 RUN level 2, turbo -> fan_level 4, countdown 3,2,1 at 4-cycle steps, then RUN level 2; second turbo ignored until power-off/on.
REQ-031 RUN, power -> COOL fan_level 1, countdown 2 -> 1 -> OFF after 8 cycles; repeat with second power in COOL -> OFF next cycle.
REQ-032 Same-cycle power+up in STANDBY -> OFF; same-cycle clean+light in STANDBY -> CLEAN, light_on unchanged.
REQ-033 buttom_rst asserted mid-CLEAN with countdown 1 -> next cycle state 0, countdown 0, light_on 0, reminder 0.
REQ-034 HOOD_REMINDER_EN: 5 s of RUN -> reminder 1; STANDBY, clean, 2 s -> reminder 0 on completion; without macro reminder stays 0.
